// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS memory stage:
//               memory-access FSM states, default bus timeout and MEM/WB
//               field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int DMEM_TIMEOUT_DEFAULT = 255;
  localparam int DATA_W               = 32;
  localparam int REG_W                = 5;
  localparam int CNT_W                = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/memory_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_if
// Description : Request/ready data-memory bus between the memory stage
//               (master) and the external data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_stage_if;
  import mips_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/writeback_reg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_reg
// Description : MEM/WB pipeline register. load captures a full instruction;
//               bubble (without load) clears the control bits and holds the
//               data fields.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              bubble,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_out_in,
  input  logic [REG_W-1:0]  write_reg_in,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [REG_W-1:0]  WriteRegW
);

  // Pipeline register: load wins over bubble; bubble only kills control.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
    end else if (load) begin
      RegWriteW <= reg_write_in;
      MemtoRegW <= mem_to_reg_in;
      ReadDataW <= read_data_in;
      ALUOutW   <= alu_out_in;
      WriteRegW <= write_reg_in;
    end else if (bubble) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : M stage of the five-stage MIPS pipeline. Issues loads and
//               stores on a request/ready bus, stalls the pipeline (Dhit=0)
//               while an access is outstanding, flags misaligned and
//               timed-out accesses, and holds the MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               RegWriteM,
  input  logic               MemtoRegM,
  input  logic               MemWriteM,
  input  logic [DATA_W-1:0]  ALUOutM,
  input  logic [DATA_W-1:0]  WriteDataM,
  input  logic [REG_W-1:0]   WriteRegM,
  memory_stage_if.master     dmem,
  output logic               Dhit,
  output logic               addr_err,
  output logic               bus_err,
  output logic               RegWriteW,
  output logic               MemtoRegW,
  output logic [DATA_W-1:0]  ReadDataW,
  output logic [DATA_W-1:0]  ALUOutW,
  output logic [REG_W-1:0]   WriteRegW
);

  // Terminal count: the abort fires in the TIMEOUT-th request cycle.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

  mem_state_t        state;
  mem_state_t        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              abort_q;

  logic access;
  logic misaligned;
  logic issue;
  logic complete;
  logic expire;
  logic suppress_wb;

  assign access      = MemtoRegM | MemWriteM;
  assign misaligned  = access & (ALUOutM[1:0] != 2'b00);
  // Completion only counts while a request is outstanding (BUSY).
  assign complete    = (state == BUSY) & dmem.mem_ready;
  assign expire      = (state == BUSY) & ~dmem.mem_ready & (cnt == TERM);
  // Misaligned or aborted instructions must not write the register file.
  assign suppress_wb = ((state == IDLE) & misaligned) | ((state == DONE) & abort_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state, stall and issue decode.
  always_comb begin
    state_next = state;
    Dhit       = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (access && !misaligned) begin
          state_next = BUSY;
          issue      = 1'b1;
        end else begin
          Dhit = 1'b1;
        end
      end
      BUSY: begin
        if (complete || expire) state_next = DONE;
      end
      DONE: begin
        Dhit       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus request, captured address/data, timeout counter and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem.mem_req   <= 1'b0;
      dmem.mem_we    <= 1'b0;
      dmem.mem_addr  <= '0;
      dmem.mem_wdata <= '0;
      cnt            <= '0;
      rdata_q        <= '0;
      abort_q        <= 1'b0;
      addr_err       <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      addr_err <= (state == IDLE) & misaligned;
      bus_err  <= expire;
      if (issue) begin
        dmem.mem_req   <= 1'b1;
        dmem.mem_we    <= MemWriteM;
        dmem.mem_addr  <= ALUOutM;
        dmem.mem_wdata <= WriteDataM;
        cnt            <= '0;
        abort_q        <= 1'b0;
      end else if (complete) begin
        dmem.mem_req <= 1'b0;
        if (!dmem.mem_we) rdata_q <= dmem.mem_rdata;
      end else if (expire) begin
        dmem.mem_req <= 1'b0;
        abort_q      <= 1'b1;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  writeback_reg u_writeback_reg (
    .clk           (clk),
    .reset         (reset),
    .load          (Dhit),
    .bubble        (~Dhit),
    .reg_write_in  (RegWriteM & ~suppress_wb),
    .mem_to_reg_in (MemtoRegM),
    .read_data_in  (rdata_q),
    .alu_out_in    (ALUOutM),
    .write_reg_in  (WriteRegM),
    .RegWriteW     (RegWriteW),
    .MemtoRegW     (MemtoRegW),
    .ReadDataW     (ReadDataW),
    .ALUOutW       (ALUOutW),
    .WriteRegW     (WriteRegW)
  );

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Directed self-checking bench for memory_stage. Instance a
//               uses the default timeout, instance b uses TIMEOUT=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        selb;
    int          total = 0;
    int          bad   = 0;

    logic        dhit_a, aerr_a, berr_a, rw_a, m2r_a;
    logic [31:0] rd_a, alu_a;
    logic [4:0]  wr_a;
    logic        dhit_b, aerr_b, berr_b, rw_b, m2r_b;
    logic [31:0] rd_b, alu_b;
    logic [4:0]  wr_b;

    memory_stage_if bus_a ();
    memory_stage_if bus_b ();

    always #5 clk = ~clk;

    memory_stage dut_a (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM & ~selb), .MemWriteM(MemWriteM & ~selb),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .dmem(bus_a),
        .Dhit(dhit_a), .addr_err(aerr_a), .bus_err(berr_a),
        .RegWriteW(rw_a), .MemtoRegW(m2r_a), .ReadDataW(rd_a), .ALUOutW(alu_a), .WriteRegW(wr_a)
    );

    memory_stage #(.TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM & selb), .MemWriteM(MemWriteM & selb),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .dmem(bus_b),
        .Dhit(dhit_b), .addr_err(aerr_b), .bus_err(berr_b),
        .RegWriteW(rw_b), .MemtoRegW(m2r_b), .ReadDataW(rd_b), .ALUOutW(alu_b), .WriteRegW(wr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg);
        RegWriteM  = rw;
        MemtoRegM  = m2r;
        MemWriteM  = mw;
        ALUOutM    = alu;
        WriteDataM = wd;
        WriteRegM  = wreg;
    endtask

    initial begin
        reset = 1'b1;
        selb  = 1'b0;
        set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        bus_a.mem_ready = 1'b0; bus_a.mem_rdata = 32'h0;
        bus_b.mem_ready = 1'b0; bus_b.mem_rdata = 32'h0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_req", bus_a.mem_req, 1'b0);
        chk("rst_addr", bus_a.mem_addr, 32'h0);
        chk("rst_rw", rw_a, 1'b0);
        chk("rst_alu", alu_a, 32'h0);
        chk("rst_dhit", dhit_a, 1'b1);
        chk("rst_berr", berr_a, 1'b0);

        // ALU instruction: single cycle, no stall
        cyc(); reset = 1'b0;
        cyc(); set_m(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd3); #1;
        chk("alu_dhit", dhit_a, 1'b1);
        cyc(); set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); #1;
        chk("alu_rw", rw_a, 1'b1);
        chk("alu_aluw", alu_a, 32'h55);
        chk("alu_wreg", wr_a, 5'd3);

        // Load to 0x100, ready at t+1
        cyc(); set_m(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7); #1;
        chk("ld_dhit_t", dhit_a, 1'b0);
        cyc(); bus_a.mem_ready = 1'b1; bus_a.mem_rdata = 32'hDEADBEEF; #1;
        chk("ld_req", bus_a.mem_req, 1'b1);
        chk("ld_we", bus_a.mem_we, 1'b0);
        chk("ld_addr", bus_a.mem_addr, 32'h100);
        chk("ld_dhit_t1", dhit_a, 1'b0);
        cyc(); bus_a.mem_ready = 1'b0; #1;
        chk("ld_req_off", bus_a.mem_req, 1'b0);
        chk("ld_dhit_t2", dhit_a, 1'b1);
        cyc(); set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); #1;
        chk("ld_rdata", rd_a, 32'hDEADBEEF);
        chk("ld_m2r", m2r_a, 1'b1);
        chk("ld_rw", rw_a, 1'b1);
        chk("ld_wreg", wr_a, 5'd7);

        // Store to 0x204, ready in the 6th request cycle
        cyc(); set_m(1'b0, 1'b0, 1'b1, 32'h204, 32'h12345678, 5'd0); #1;
        chk("st_dhit_t", dhit_a, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            cyc(); bus_a.mem_ready = (i == 6); #1;
            chk("st_req", bus_a.mem_req, 1'b1);
            chk("st_we", bus_a.mem_we, 1'b1);
            chk("st_addr", bus_a.mem_addr, 32'h204);
            chk("st_wdata", bus_a.mem_wdata, 32'h12345678);
            chk("st_dhit", dhit_a, 1'b0);
        end
        cyc(); bus_a.mem_ready = 1'b0; #1;
        chk("st_done_dhit", dhit_a, 1'b1);
        chk("st_done_req", bus_a.mem_req, 1'b0);
        cyc(); set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); #1;
        chk("st_rw", rw_a, 1'b0);
        chk("st_aluw", alu_a, 32'h204);

        // Misaligned load at 0x102
        cyc(); set_m(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd9); #1;
        chk("mis_dhit", dhit_a, 1'b1);
        cyc(); set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); #1;
        chk("mis_aerr", aerr_a, 1'b1);
        chk("mis_req", bus_a.mem_req, 1'b0);
        chk("mis_rw", rw_a, 1'b0);
        chk("mis_aluw", alu_a, 32'h102);
        cyc(); #1;
        chk("mis_aerr_off", aerr_a, 1'b0);

        // TIMEOUT=4 instance: ready never comes
        selb = 1'b1;
        cyc(); set_m(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd4); #1;
        chk("to_dhit_t", dhit_b, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc(); #1;
            chk("to_req", bus_b.mem_req, 1'b1);
            chk("to_berr_low", berr_b, 1'b0);
        end
        cyc(); #1;
        chk("to_req_off", bus_b.mem_req, 1'b0);
        chk("to_berr", berr_b, 1'b1);
        chk("to_dhit_done", dhit_b, 1'b1);
        cyc(); set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); #1;
        chk("to_rw", rw_b, 1'b0);
        chk("to_berr_off", berr_b, 1'b0);
        chk("to_idle_dhit", dhit_b, 1'b1);

        // TIMEOUT=4 instance: ready on the terminal cycle wins
        cyc(); set_m(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd5); #1;
        for (int i = 1; i <= 4; i++) begin
            cyc(); bus_b.mem_ready = (i == 4); bus_b.mem_rdata = 32'hCAFEF00D; #1;
            chk("tr_req", bus_b.mem_req, 1'b1);
        end
        cyc(); bus_b.mem_ready = 1'b0; #1;
        chk("tr_berr", berr_b, 1'b0);
        chk("tr_dhit", dhit_b, 1'b1);
        cyc(); set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); #1;
        chk("tr_rdata", rd_b, 32'hCAFEF00D);
        chk("tr_rw", rw_b, 1'b1);

        // Stray ready with no request is ignored
        bus_b.mem_ready = 1'b1;
        cyc(); #1;
        chk("stray_req", bus_b.mem_req, 1'b0);
        chk("stray_dhit", dhit_b, 1'b1);
        bus_b.mem_ready = 1'b0;
        selb = 1'b0;

        // Reset while BUSY
        cyc(); set_m(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd6); #1;
        cyc(); #1;
        chk("rb_req", bus_a.mem_req, 1'b1);
        reset = 1'b1;
        cyc(); #1;
        chk("rb_req_off", bus_a.mem_req, 1'b0);
        chk("rb_rd", rd_a, 32'h0);
        chk("rb_alu", alu_a, 32'h0);
        chk("rb_rw", rw_a, 1'b0);
        chk("rb_m2r", m2r_a, 1'b0);
        chk("rb_wreg", wr_a, 5'd0);
        reset = 1'b0;
        set_m(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd2); #1;
        chk("rb_alu_dhit", dhit_a, 1'b1);
        cyc(); set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0); #1;
        chk("rb_alu_rw", rw_a, 1'b1);
        chk("rb_alu_aluw", alu_a, 32'h77);

        if (bad == 0) $display("PASS test done: total=%0d bad=%0d", total, bad);
        else          $display("FAIL test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_stage.md
# memory_stage

Data-memory access stage of the five-stage MIPS pipeline, sitting directly downstream of the EX/MEM pipeline register and feeding writeback. Converts the M-stage load/store control into a request/ready handshake on an external data-memory bus, generates the global `Dhit` stall signal, and contains the MEM/WB pipeline register. The EX/MEM register holds its contents while `Dhit` is low, so this block's inputs stay stable for the whole access.

## Interface
- `TIMEOUT`, 255: max cycles in BUSY without `mem_ready` before abort; 1..255.
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `RegWriteM`, `MemtoRegM`, `MemWriteM`  in  1 each  M-stage control from EX/MEM register
- `ALUOutM`  in  32  effective address / ALU result
- `WriteDataM`  in  32  store data
- `WriteRegM`  in  5  destination register
- `mem_req`  out  1  bus request, registered
- `mem_we`  out  1  1 = store, 0 = load; valid while `mem_req`
- `mem_addr`  out  32  word address (`ALUOutM` captured at issue)
- `mem_wdata`  out  32  store data captured at issue
- `mem_ready`  in  1  bus completion, sampled while `mem_req` high
- `mem_rdata`  in  32  load data, valid when `mem_ready`
- `Dhit`  out  1  1 = M stage may advance; 0 = stall whole pipeline
- `addr_err`  out  1  one-cycle pulse: misaligned access, suppressed
- `bus_err`  out  1  one-cycle pulse: access aborted by timeout
- `RegWriteW`, `MemtoRegW`  out  1 each  MEM/WB control
- `ReadDataW`, `ALUOutW`  out  32 each  load data / ALU result
- `WriteRegW`  out  5  destination register

## Operation
- Access = `MemtoRegM | MemWriteM`. Misaligned = access with `ALUOutM[1:0] != 0`.
- FSM states IDLE, BUSY, DONE (enum in package).
- IDLE: access and aligned -> BUSY; capture addr/wdata/we; set `mem_req`; clear timeout counter; `Dhit`=0. Misaligned -> stay IDLE, `addr_err`=1, `Dhit`=1, no request. Non-access -> `Dhit`=1.
- BUSY: `Dhit`=0. `mem_ready`=1 -> DONE, clear `mem_req`, capture `mem_rdata` (loads). Else counter == TIMEOUT-1 -> DONE with abort flag, clear `mem_req`. Else counter++.
- DONE: `Dhit`=1, MEM/WB latches the instruction, -> IDLE unconditionally. Inputs in DONE are still the completed instruction and never re-issue.
- MEM/WB load when `Dhit`=1: `ReadDataW` = captured data; other fields from M inputs. `RegWriteW` forced 0 on misaligned or aborted access. When `Dhit`=0, load a bubble: `RegWriteW`=0, `MemtoRegW`=0, data fields hold.
- `bus_err` pulses in DONE of an aborted access.

## Timing
- Reset: state IDLE; `mem_req`, `mem_we`, `addr_err`, `bus_err`, all W outputs 0; `mem_addr`/`mem_wdata` 0; counter 0. `Dhit` is combinational from the reset state and inputs.
- Non-memory instruction: one cycle in M, `Dhit`=1.
- Access presented at cycle t: `Dhit`=0 at t. `mem_req` high from t+1. If `mem_ready` at t+1, DONE at t+2 and W outputs valid at t+3. Minimum 3 cycles in M.
- `mem_req`/addr/data stay stable until `mem_ready` is sampled. `mem_req` is low in the cycle after.
- `mem_ready` in the same cycle as the timeout terminal count: ready wins, no `bus_err`.
- `mem_ready` while `mem_req`=0: ignored.
- Reset mid-access: IDLE next edge; `mem_req` drops; outstanding bus transaction abandoned.

## Structure
- `mips_pkg`: `mem_state_t` enum, `DMEM_TIMEOUT_DEFAULT`, MEM/WB field widths.
- Sub-module `writeback_reg`: MEM/WB register with load-enable and bubble-insert inputs. FSM and bus capture live in `memory_stage`.

## Test plan
- Load to 0x100, `mem_ready` at t+1, rdata 0xDEADBEEF -> `Dhit` low at t and t+1. At t+3: `ReadDataW`=0xDEADBEEF, `MemtoRegW`=1, `RegWriteW`=1.
- Store to 0x204, data 0x12345678, ready delayed 5 cycles -> `mem_we`=1, addr and data stable for all 6 request cycles. `Dhit` low for 7 cycles. `RegWriteW`=0.
- Load at 0x102 -> `addr_err` pulse, `mem_req` never asserted, `Dhit`=1, `RegWriteW`=0 next cycle.
- TIMEOUT=4, `mem_ready` held low -> `mem_req` high for 4 cycles, then `bus_err` pulse. `RegWriteW`=0; FSM returns to IDLE.
- TIMEOUT=4, `mem_ready` on the terminal cycle -> normal completion, no `bus_err`.
- `reset` asserted while BUSY -> next cycle `mem_req`=0, IDLE, all W outputs 0. Next ALU instruction passes with `Dhit`=1.
